// File: rtl/serial_add.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, through a
// registered carry. The result, carry-out and signed overflow are registered with a one-cycle done pulse.
module serial_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic             state;
  logic [WIDTH-1:0] opa, opb, acc;
  logic             carry, sa, sb;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_nxt, opb_in;
  logic             last;

  always_comb begin
    dsum    = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Concatenate-then-shift keeps this legal when DIGIT == WIDTH.
    acc_nxt = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);
    opb_in  = b ^ {WIDTH{sub}};
    last    = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= opb_in;
            carry <= sub;
            cnt   <= '0;
            sa    <= a[WIDTH-1];
            sb    <= opb_in[WIDTH-1];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum   <= acc_nxt;
            cout  <= dsum[DIGIT];
            ovf   <= (sa == sb) && (acc_nxt[WIDTH-1] != sa);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add: one DUT at DIGIT=1, one at DIGIT=4, each
// with an expected-result queue drained by a monitor on every done pulse.
module tb_serial_add;
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       start8 = 0, sub8 = 0, start4 = 0, sub4 = 0;
  logic [7:0] a8 = 0, b8 = 0, a4 = 0, b4 = 0;
  logic       busy8, done8, cout8, ovf8, busy4, done4, cout4, ovf4;
  logic [7:0] sum8, sum4;

  serial_add #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_add #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  exp_t q8[$];
  exp_t q4[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse, including its due cycle.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("d1_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("d1_sum", sum8, e.s);
        chk("d1_cout", cout8, e.c);
        chk("d1_ovf", ovf8, e.v);
        chk("d1_done_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) chk("d4_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("d4_sum", sum4, e.s);
        chk("d4_cout", cout4, e.c);
        chk("d4_ovf", ovf4, e.v);
        chk("d4_done_cycle", cyc, e.due);
      end
    end
  end

  // One operation on DUT d (0: DIGIT=1, 1: DIGIT=4); checks busy length too.
  task automatic run_op(input int d, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, input logic [7:0] es, input logic ec,
                        input logic ev);
    exp_t e;
    int n;
    int bcnt;
    n = (d == 0) ? 8 : 2;
    bcnt = 0;
    @(negedge clk);
    e.s = es; e.c = ec; e.v = ev; e.due = cyc + 1 + n;
    if (d == 0) begin a8 = ta; b8 = tb_; sub8 = ts; start8 = 1; q8.push_back(e); end
    else        begin a4 = ta; b4 = tb_; sub4 = ts; start4 = 1; q4.push_back(e); end
    @(negedge clk);
    start8 = 0; start4 = 0;
    for (int i = 0; i < 40; i++) begin
      if (((d == 0) ? busy8 : busy4) !== 1'b1) break;
      bcnt++;
      @(negedge clk);
    end
    chk((d == 0) ? "d1_busy_cycles" : "d4_busy_cycles", bcnt, n);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] ha[3];
    logic [7:0] hb[3];
    logic [7:0] hs[3];
    logic       hc[3];
    logic [7:0] prev;
    exp_t e;
    bit seen;

    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    run_op(0, 8'h35, 8'h4A, 0, 8'h7F, 0, 0);
    run_op(0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);
    run_op(0, 8'h7F, 8'h01, 0, 8'h80, 0, 1);
    run_op(0, 8'h10, 8'h20, 1, 8'hF0, 0, 0);
    run_op(0, 8'h80, 8'h01, 1, 8'h7F, 1, 1);

    // start held high; operands change during RUN and must not matter.
    ha = '{8'h12, 8'hC0, 8'h12};
    hb = '{8'h34, 8'h50, 8'h34};
    hs = '{8'h46, 8'h10, 8'h46};
    hc = '{1'b0, 1'b1, 1'b0};
    prev = 8'h7F;
    @(negedge clk);
    a8 = ha[0]; b8 = hb[0]; sub8 = 0; start8 = 1;
    e.s = hs[0]; e.c = hc[0]; e.v = 0; e.due = cyc + 9;
    q8.push_back(e);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; sub8 = 1;
      @(negedge clk);
      chk("hold_sum_kept", sum8, prev);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done8 === 1'b1) begin seen = 1; break; end
      end
      chk("hold_done_seen", seen, 1);
      prev = hs[k];
      if (k < 2) begin
        a8 = ha[k+1]; b8 = hb[k+1]; sub8 = 0;
        e.s = hs[k+1]; e.c = hc[k+1]; e.v = 0; e.due = cyc + 9;
        q8.push_back(e);
      end else start8 = 0;
    end
    @(negedge clk);
    @(negedge clk);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; sub8 = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    chk("abort_ovf", ovf8, 0);
    @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", busy8, 0);
    run_op(0, 8'h01, 8'h02, 0, 8'h03, 0, 0);

    run_op(1, 8'hA5, 8'h5B, 0, 8'h00, 1, 0);
    run_op(1, 8'h70, 8'h10, 0, 8'h80, 0, 1);
    run_op(1, 8'h80, 8'h01, 1, 8'h7F, 1, 1);

    repeat (4) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/serial_add.md
# serial_add

Parametrised digit-serial adder/subtractor, the sequential successor to the combinational half/full adder cells in this library. It accepts two WIDTH-bit operands on a start strobe and processes DIGIT bits per clock, LSB first, through a registered carry chain. It then presents the sum, carry-out and signed-overflow flag with a one-cycle done pulse. It serves area-constrained datapaths where a full-width ripple adder is too large.

## Interface
- WIDTH, default 8: operand and result width in bits; must be ≥ 2.
- DIGIT, default 1: bits processed per clock; WIDTH must be an integer multiple of DIGIT. N = WIDTH/DIGIT digit cycles per operation.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  operation request, sampled only in IDLE.
- sub  input  1  0 = add (a+b), 1 = subtract (a−b); sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse, result valid.
- sum  output  WIDTH  result, mod 2^WIDTH.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- On reset, all outputs and internal registers are 0: busy=0, done=0, sum=0, cout=0, ovf=0.
- IDLE with start=1 at an edge:
  - Latch opa=a and opb = b XOR {WIDTH{sub}}.
  - Set carry=sub and cnt=0.
  - Latch sa=a[WIDTH-1] and sb=opb[WIDTH-1].
  - Set busy=1 and go to RUN.
- IDLE with start=0: hold.
- RUN, each edge:
  - Compute the (DIGIT+1)-bit value opa[DIGIT-1:0] + opb[DIGIT-1:0] + carry.
  - Shift its low DIGIT bits into the top of an internal accumulator (acc ← {dsum, acc[WIDTH-1:DIGIT]}).
  - Shift opa and opb right by DIGIT.
  - Set carry to the digit carry-out and increment cnt.
- RUN, edge with cnt = N−1: perform the digit step, then:
  - sum ← final accumulator value.
  - cout ← final digit carry.
  - ovf ← (sa == sb) && (sum MSB != sa).
  - busy ← 0, done ← 1, next state IDLE.
- done is cleared on the following edge unconditionally.
- sum, cout and ovf are registered. They change only at completion or reset, and hold their values through later operations until the next completion.
- start while RUN is ignored. start is not queued, and a, b and sub changes while RUN have no effect.
- start high during the done cycle is sampled in IDLE and accepted.
- rst asserted mid-operation aborts immediately. The partial result is discarded, no done pulse occurs, and all outputs go to 0.

## Timing
- Let start be accepted at edge t0.
- busy rises after t0 and falls after edge t0+N.
- done is high for exactly the one cycle between edges t0+N and t0+N+1. sum, cout and ovf are valid from edge t0+N.
- Latency is N cycles from start to done. Maximum throughput is one operation per N+1 cycles.
- rst acts combinationally on all registers with no clock required. Release is synchronous to the next rising edge as far as start sampling is concerned.

## Test plan
- WIDTH=8, DIGIT=1, a=8'h35, b=8'h4A, sub=0 → done exactly 8 cycles after start; sum=8'h7F, cout=0, ovf=0; busy high for 8 cycles.
- WIDTH=8, DIGIT=1:
  - 8'hFF+8'h01 → sum=8'h00, cout=1, ovf=0.
  - then 8'h7F+8'h01 → sum=8'h80, cout=0, ovf=1.
- WIDTH=8, DIGIT=1, sub=1:
  - 8'h10−8'h20 → sum=8'hF0, cout=0, ovf=0.
  - 8'h80−8'h01 → sum=8'h7F, cout=1, ovf=1.
- Hold start=1 throughout with alternating operands → new operands are taken only in IDLE; done pulses are spaced 9 cycles apart. Operand changes during RUN do not alter the result. sum holds its previous value until each completion.
- Assert rst at cycle 3 of an operation → busy, done, sum, cout and ovf are 0 before the next edge; no done pulse follows. A fresh start after release completes normally.
- WIDTH=8, DIGIT=4, a=8'hA5, b=8'h5B, sub=0 → done 2 cycles after start; sum=8'h00, cout=1, ovf=0.
